// File: rtl/serv_bridge_pkg.sv
// Shared types and helpers for the Wishbone-to-byte-SRAM bridge: FSM encoding,
// lane-index width, the "no further lane" sentinel and a lowest-set-lane finder.
package serv_bridge_pkg;

  localparam int LANE_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR     = 3'd1,
    ST_RD     = 3'd2,
    ST_RDLAST = 3'd3,
    ST_ACK    = 3'd4
  } state_e;

  // MSB set marks "no set lane found"; lower bits are don't-care.
  localparam logic [LANE_W:0] NO_LANE = 3'b100;

  function automatic logic [LANE_W-1:0] first_set_lane(input logic [3:0] mask);
    logic [LANE_W-1:0] lane;
    lane = 2'd0;
    if (mask[0])      lane = 2'd0;
    else if (mask[1]) lane = 2'd1;
    else if (mask[2]) lane = 2'd2;
    else if (mask[3]) lane = 2'd3;
    else              lane = 2'd0;
    return lane;
  endfunction

endpackage

// File: rtl/serv_byte_lane_seq.sv
// Combinational next-set-lane finder: given a lane mask and the current lane,
// returns the next higher set lane and flags when the current lane is the last.
module serv_byte_lane_seq
  import serv_bridge_pkg::*;
(
  input  logic [3:0]        mask_i,
  input  logic [LANE_W-1:0] lane_i,
  output logic [LANE_W-1:0] next_o,
  output logic              last_o
);

  logic [3:0]      higher_s;
  logic [3:0]      cand_s;
  logic [LANE_W:0] found_s;

  // Lanes strictly above the current one; the index never wraps past lane 3.
  always_comb begin
    higher_s = 4'b0000;
    case (lane_i)
      2'd0:    higher_s = 4'b1110;
      2'd1:    higher_s = 4'b1100;
      2'd2:    higher_s = 4'b1000;
      default: higher_s = 4'b0000;
    endcase
    cand_s = mask_i & higher_s;
    if (cand_s == 4'b0000) found_s = NO_LANE;
    else                   found_s = {1'b0, first_set_lane(cand_s)};
  end

  assign next_o = found_s[LANE_W-1:0];
  assign last_o = (found_s == NO_LANE);

endmodule

// File: rtl/serv_wb_byte_bridge.sv
// Wishbone classic responder that splits 32-bit accesses into byte cycles on an
// 8-bit synchronous SRAM. Define SERV_WB_BYTE_BRIDGE_RDSEL_EN to make reads honour i_wb_sel.
module serv_wb_byte_bridge
  import serv_bridge_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [AW-3:0] i_wb_adr,
  input  logic [31:0]   i_wb_dat,
  input  logic [3:0]    i_wb_sel,
  input  logic          i_wb_we,
  input  logic          i_wb_stb,
  output logic [31:0]   o_wb_rdt,
  output logic          o_wb_ack,
  output logic [AW-1:0] o_mem_adr,
  output logic [7:0]    o_mem_wdat,
  output logic          o_mem_we,
  output logic          o_mem_re,
  input  logic [7:0]    i_mem_rdat
);

  state_e            state_q, state_d;
  logic [AW-3:0]     adr_q, adr_d;
  logic [31:0]       dat_q, dat_d;
  logic [3:0]        sel_q, sel_d;
  logic              we_q, we_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic              rd_pend_q, rd_pend_d;
  logic [LANE_W-1:0] pend_lane_q, pend_lane_d;
  logic [31:0]       rdt_q, rdt_d;

  logic [3:0]        mask_s;
  logic [LANE_W-1:0] next_lane_s;
  logic              last_lane_s;

`ifdef SERV_WB_BYTE_BRIDGE_RDSEL_EN
  assign mask_s = sel_q;
`else
  assign mask_s = we_q ? sel_q : 4'hF;
`endif

  serv_byte_lane_seq u_lane_seq (
    .mask_i (mask_s),
    .lane_i (lane_q),
    .next_o (next_lane_s),
    .last_o (last_lane_s)
  );

  // Next-state logic: request latching, lane sequencing and read-byte capture.
  always_comb begin
    state_d     = state_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    we_d        = we_q;
    lane_d      = lane_q;
    rd_pend_d   = 1'b0;
    pend_lane_d = lane_q;
    rdt_d       = rdt_q;

    // SRAM data for the lane issued last cycle is valid now.
    if (rd_pend_q) rdt_d[{pend_lane_q, 3'b000} +: 8] = i_mem_rdat;
    else           rdt_d = rdt_q;

    case (state_q)
      ST_IDLE: begin
        if (i_wb_stb && !o_wb_ack) begin
          adr_d = i_wb_adr;
          dat_d = i_wb_dat;
          sel_d = i_wb_sel;
          we_d  = i_wb_we;
          if (i_wb_we) begin
            if (i_wb_sel != 4'b0000) begin
              state_d = ST_WR;
              lane_d  = first_set_lane(i_wb_sel);
            end else begin
              state_d = ST_ACK;
            end
          end else begin
`ifdef SERV_WB_BYTE_BRIDGE_RDSEL_EN
            rdt_d = 32'h0000_0000;
            if (i_wb_sel != 4'b0000) begin
              state_d = ST_RD;
              lane_d  = first_set_lane(i_wb_sel);
            end else begin
              state_d = ST_ACK;
            end
`else
            state_d = ST_RD;
            lane_d  = 2'd0;
`endif
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR: begin
        if (last_lane_s) state_d = ST_ACK;
        else             lane_d  = next_lane_s;
      end
      ST_RD: begin
        rd_pend_d = 1'b1;
        if (last_lane_s) state_d = ST_RDLAST;
        else             lane_d  = next_lane_s;
      end
      ST_RDLAST: state_d = ST_ACK;
      ST_ACK:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any access in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      adr_q       <= '0;
      dat_q       <= 32'h0000_0000;
      sel_q       <= 4'b0000;
      we_q        <= 1'b0;
      lane_q      <= 2'd0;
      rd_pend_q   <= 1'b0;
      pend_lane_q <= 2'd0;
      rdt_q       <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      lane_q      <= lane_d;
      rd_pend_q   <= rd_pend_d;
      pend_lane_q <= pend_lane_d;
      rdt_q       <= rdt_d;
    end
  end

  assign o_wb_ack   = (state_q == ST_ACK);
  assign o_wb_rdt   = rdt_q;
  assign o_mem_adr  = {adr_q, lane_q};
  assign o_mem_wdat = dat_q[{lane_q, 3'b000} +: 8];
  assign o_mem_we   = (state_q == ST_WR) & we_q;
  assign o_mem_re   = (state_q == ST_RD) & ~we_q;

endmodule

// File: tb/tb_serv_wb_byte_bridge.sv
// Self-checking bench for serv_wb_byte_bridge: a byte RAM model answers the SRAM
// port while expected strobes and responses are queued on drive and popped on output.
module tb_serv_wb_byte_bridge;

  localparam int AW = 10;

  logic          i_clk;
  logic          i_rst_n;
  logic [AW-3:0] i_wb_adr;
  logic [31:0]   i_wb_dat;
  logic [3:0]    i_wb_sel;
  logic          i_wb_we;
  logic          i_wb_stb;
  logic [31:0]   o_wb_rdt;
  logic          o_wb_ack;
  logic [AW-1:0] o_mem_adr;
  logic [7:0]    o_mem_wdat;
  logic          o_mem_we;
  logic          o_mem_re;
  logic [7:0]    i_mem_rdat;

  serv_wb_byte_bridge #(.AW(AW)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_wb_adr   (i_wb_adr),
    .i_wb_dat   (i_wb_dat),
    .i_wb_sel   (i_wb_sel),
    .i_wb_we    (i_wb_we),
    .i_wb_stb   (i_wb_stb),
    .o_wb_rdt   (o_wb_rdt),
    .o_wb_ack   (o_wb_ack),
    .o_mem_adr  (o_mem_adr),
    .o_mem_wdat (o_mem_wdat),
    .o_mem_we   (o_mem_we),
    .o_mem_re   (o_mem_re),
    .i_mem_rdat (i_mem_rdat)
  );

  typedef struct {
    bit         we;
    logic [9:0] adr;
    logic [7:0] dat;
  } strobe_t;

  typedef struct {
    int          lat;
    logic [31:0] rdt;
  } resp_t;

  strobe_t     sq[$];
  resp_t       rq[$];
  logic [7:0]  phys_mem [0:1023];
  logic [7:0]  ref_mem  [0:1023];
  logic [31:0] exp_rdt_last;
  bit          prev_hold;
  int          checks;
  int          failures;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Synchronous byte RAM: read data appears the cycle after o_mem_re.
  always @(posedge i_clk) begin
    if (o_mem_we) phys_mem[o_mem_adr] <= o_mem_wdat;
    if (o_mem_re) i_mem_rdat <= phys_mem[o_mem_adr];
  end

  function automatic int exp_latency(input logic [3:0] sel, input logic we);
    int n;
    n = $countones(sel);
    if (we) return (n == 0) ? 1 : n + 1;
`ifdef SERV_WB_BYTE_BRIDGE_RDSEL_EN
    return (n == 0) ? 1 : n + 2;
`else
    return 6;
`endif
  endfunction

  task automatic run_access(input logic [7:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input logic we,
                            input bit hold, input bit drop, input string name);
    resp_t       r;
    strobe_t     s;
    strobe_t     got;
    logic [31:0] rdt_e;
    logic [9:0]  badr;
    int          c;
    bit          done;
    bit          use_lane;
    r.lat = exp_latency(sel, we) + (prev_hold ? 1 : 0);
    rdt_e = 32'h0;
    for (int k = 0; k < 4; k++) begin
      badr = {adr, 2'(k)};
`ifdef SERV_WB_BYTE_BRIDGE_RDSEL_EN
      use_lane = sel[k];
`else
      use_lane = we ? sel[k] : 1'b1;
`endif
      if (use_lane) begin
        s.we  = we;
        s.adr = badr;
        s.dat = we ? dat[8*k +: 8] : 8'h00;
        sq.push_back(s);
        if (we) ref_mem[badr] = dat[8*k +: 8];
        else    rdt_e[8*k +: 8] = ref_mem[badr];
      end
    end
    if (!we) exp_rdt_last = rdt_e;
    r.rdt = exp_rdt_last;
    rq.push_back(r);

    i_wb_adr = adr;
    i_wb_dat = dat;
    i_wb_sel = sel;
    i_wb_we  = we;
    i_wb_stb = 1'b1;
    c    = 0;
    done = 1'b0;
    while (!done && c < 40) begin
      @(posedge i_clk);
      #1;
      c++;
      if (drop && c == 1) begin
        i_wb_stb = 1'b0;
        i_wb_dat = ~dat;
        i_wb_sel = ~sel;
        i_wb_adr = ~adr;
        i_wb_we  = ~we;
      end
      checks++;
      if (o_mem_we && o_mem_re) begin
        failures++;
        $display("FAIL %s both_strobes: we=%b re=%b required not both high", name, o_mem_we, o_mem_re);
      end
      if (o_mem_we || o_mem_re) begin
        checks++;
        if (sq.size() == 0) begin
          failures++;
          $display("FAIL %s extra_strobe: we=%b re=%b adr=%h required none", name, o_mem_we, o_mem_re, o_mem_adr);
        end else begin
          got = sq.pop_front();
          if (o_mem_we !== got.we || o_mem_adr !== got.adr || (got.we && o_mem_wdat !== got.dat)) begin
            failures++;
            $display("FAIL %s strobe: got we=%b adr=%h wdat=%h required we=%b adr=%h wdat=%h",
                     name, o_mem_we, o_mem_adr, o_mem_wdat, got.we, got.adr, got.dat);
          end
        end
      end
      if (o_wb_ack) begin
        done = 1'b1;
        r = rq.pop_front();
        checks += 3;
        if (c !== r.lat) begin
          failures++;
          $display("FAIL %s ack_cycle: got %0d required %0d", name, c, r.lat);
        end
        if (o_wb_rdt !== r.rdt) begin
          failures++;
          $display("FAIL %s rdt: got %h required %h", name, o_wb_rdt, r.rdt);
        end
        if (sq.size() != 0) begin
          failures++;
          $display("FAIL %s missing_strobes: got %0d outstanding required 0", name, sq.size());
        end
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s timeout: no ack within %0d cycles required ack", name, c);
      sq.delete();
      rq.delete();
    end
    if (!hold) begin
      i_wb_stb = 1'b0;
      @(posedge i_clk);
      #1;
      checks++;
      if (o_wb_ack !== 1'b0) begin
        failures++;
        $display("FAIL %s ack_width: got ack=%b after pulse required 0", name, o_wb_ack);
      end
    end
    prev_hold = hold;
  endtask

  task automatic test_reset();
    i_rst_n  = 1'b0;
    i_wb_adr = 8'h00;
    i_wb_dat = 32'h0;
    i_wb_sel = 4'h0;
    i_wb_we  = 1'b0;
    i_wb_stb = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      phys_mem[i] = 8'h00;
      ref_mem[i]  = 8'h00;
    end
    exp_rdt_last = 32'h0;
    prev_hold    = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    checks++;
    if (o_wb_ack !== 1'b0 || o_mem_we !== 1'b0 || o_mem_re !== 1'b0 || o_wb_rdt !== 32'h0) begin
      failures++;
      $display("FAIL reset: got ack=%b we=%b re=%b rdt=%h required 0 0 0 00000000",
               o_wb_ack, o_mem_we, o_mem_re, o_wb_rdt);
    end
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_full_write_read();
    run_access(8'h05, 32'hA1B2C3D4, 4'hF, 1'b1, 1'b0, 1'b0, "full_write");
    run_access(8'h05, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0, "full_read");
    checks++;
    if (o_wb_rdt !== 32'hA1B2C3D4) begin
      failures++;
      $display("FAIL full_read_hold: got %h required a1b2c3d4", o_wb_rdt);
    end
  endtask

  task automatic test_sparse_write();
    run_access(8'h05, 32'h11223344, 4'b1010, 1'b1, 1'b0, 1'b0, "sparse_write");
    run_access(8'h05, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0, "sparse_readback");
    checks++;
    if (o_wb_rdt !== 32'h11B233D4) begin
      failures++;
      $display("FAIL sparse_readback_value: got %h required 11b233d4", o_wb_rdt);
    end
  endtask

  task automatic test_sel_zero();
    run_access(8'h09, 32'hDEADBEEF, 4'h0, 1'b1, 1'b0, 1'b0, "sel0_write");
    run_access(8'h05, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, "sel0_read");
    run_access(8'h05, 32'h0, 4'b0100, 1'b0, 1'b0, 1'b0, "sel4_read");
  endtask

  task automatic test_latched_fields();
    run_access(8'h21, 32'h55AA6699, 4'b0110, 1'b1, 1'b0, 1'b1, "latched_write");
    run_access(8'h21, 32'h0, 4'hF, 1'b0, 1'b0, 1'b1, "latched_read");
  endtask

  task automatic test_boundary();
    run_access(8'hFF, 32'h87654321, 4'b1001, 1'b1, 1'b0, 1'b0, "top_write");
    run_access(8'hFF, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0, "top_read");
    run_access(8'h00, 32'h0000007E, 4'b0001, 1'b1, 1'b0, 1'b0, "bottom_write");
    run_access(8'h00, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0, "bottom_read");
  endtask

  task automatic test_reset_mid_read();
    int  c;
    bit  hit;
    i_wb_adr = 8'h05;
    i_wb_sel = 4'hF;
    i_wb_we  = 1'b0;
    i_wb_stb = 1'b1;
    c   = 0;
    hit = 1'b0;
    while (!hit && c < 20) begin
      @(posedge i_clk);
      #1;
      c++;
      if (o_mem_re && o_mem_adr[1:0] == 2'd2) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL mid_read_lane2: got no lane 2 read within %0d cycles required one", c);
    end
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (o_wb_ack !== 1'b0 || o_mem_re !== 1'b0 || o_mem_we !== 1'b0 || o_wb_rdt !== 32'h0) begin
      failures++;
      $display("FAIL mid_read_reset: got ack=%b re=%b we=%b rdt=%h required 0 0 0 00000000",
               o_wb_ack, o_mem_re, o_mem_we, o_wb_rdt);
    end
    i_wb_stb     = 1'b0;
    exp_rdt_last = 32'h0;
    prev_hold    = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    run_access(8'h33, 32'hCAFEF00D, 4'hF, 1'b1, 1'b0, 1'b0, "post_reset_write");
    run_access(8'h33, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0, "post_reset_read");
  endtask

  task automatic test_back_to_back();
    logic [7:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    for (int i = 0; i < 20; i++) begin
      adr = 8'($urandom_range(0, 7));
      dat = $urandom;
      sel = 4'($urandom_range(0, 15));
      we  = 1'($urandom_range(0, 1));
      run_access(adr, dat, sel, we, (i != 19), 1'b0, "b2b");
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_full_write_read();
    test_sparse_write();
    test_sel_zero();
    test_latched_fields();
    test_boundary();
    test_reset_mid_read();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
